mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter that shares one single-port memory between instruction
// fetch and data access. Each grant takes a fixed three cycles: IDLE, ACCESS, RESP.
module mem_arbiter #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 16
) (
  input  logic          clk_main,
  input  logic          reset,

  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;            // 0: fetch wins a tie, 1: data wins a tie
  logic          win_data_q, win_data_d;  // current grant belongs to the data port
  logic          wr_q, wr_d;              // current grant is a data write
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          grant_data;
  logic          if_ack_c, d_ack_c;

  // Data wins when it is the only requester or when the pointer favours it.
  assign grant_data = d_req && (!if_req || ptr_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_data_d  = win_data_q;
    wr_d        = wr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_c    = 1'b0;
    d_ack_c     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          state_d    = StAccess;
          win_data_d = grant_data;
          ptr_d      = !grant_data;
          mem_en_d   = 1'b1;
          if (grant_data) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            wr_d        = d_we;
          end else begin
            mem_addr_d  = if_addr;
            wr_d        = 1'b0;
          end
        end
      end
      StAccess: begin
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
        if (win_data_q) begin
          d_ack_c = 1'b1;
          if (!wr_q) begin
            d_rdata_d = mem_rdata;
          end
        end else begin
          if_ack_c   = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      win_data_q  <= 1'b0;
      wr_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_data_q  <= win_data_d;
      wr_q        <= wr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_c;
  assign d_ack     = d_ack_c;

  // Memory data arrives during RESP, so the ack cycle forwards it straight through;
  // the registers take over from the following cycle and hold until the next ack.
  assign if_rdata  = if_ack_c ? mem_rdata : if_rdata_q;
  assign d_rdata   = (d_ack_c && !wr_q) ? mem_rdata : d_rdata_q;

  ack_exclusive_a : assert property (@(posedge clk_main) disable iff (!reset)
    !(if_ack && d_ack));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory and an
// in-order scoreboard of expected acks.
module tb_mem_arbiter;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;

  logic          clk_main;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_main (clk_main),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk_main = 1'b0;
  always #5 clk_main = ~clk_main;

  logic [DW-1:0] mem [64];

  always @(posedge clk_main) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct packed {
    logic          is_data;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;
  bit   keep_if;
  bit   keep_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic is_data, input logic [DW-1:0] v);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = v;
    sb.push_back(e);
  endtask

  // One clock; outputs observed 1 time unit after the edge, acks scored in order.
  task automatic step();
    exp_t e;
    @(posedge clk_main);
    #1;
    check("ack_overlap", 32'(if_ack && d_ack), 32'h0);
    if (if_ack || d_ack) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_ack: observed if_ack=%0b d_ack=%0b expected no ack",
               if_ack, d_ack);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ack_port", 32'(d_ack), 32'(e.is_data));
        check("ack_rdata", e.is_data ? 32'(d_rdata) : 32'(if_rdata), 32'(e.rdata));
      end
      if (if_ack && !keep_if) if_req = 1'b0;
      if (d_ack && !keep_d) d_req = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("sb_drain", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    keep_if = 1'b0;
    keep_d  = 1'b0;
    reset   = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    mem_rdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[6'h05] = 16'h1234;
    mem[6'h10] = 16'h0A0A;

    // Reset values
    #2;
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_if_ack", 32'(if_ack), 32'h0);
    check("rst_d_ack", 32'(d_ack), 32'h0);
    check("rst_if_rdata", 32'(if_rdata), 32'h0);
    check("rst_d_rdata", 32'(d_rdata), 32'h0);
    @(negedge clk_main);
    reset = 1'b1;

    // Fetch only; address changed after grant must not matter
    if_req  = 1'b1;
    if_addr = 6'h05;
    exp_push(1'b0, 16'h1234);
    step();
    check("fetch_mem_en", 32'(mem_en), 32'h1);
    check("fetch_mem_we", 32'(mem_we), 32'h0);
    check("fetch_mem_addr", 32'(mem_addr), 32'h05);
    if_addr = 6'h07;
    step();
    check("fetch_ack_cycle", 32'(if_ack), 32'h1);
    check("fetch_en_drop", 32'(mem_en), 32'h0);
    step();
    step();
    check("if_rdata_hold", 32'(if_rdata), 32'h1234);

    // Data write 0xBEEF to 0x3F, then read it back
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 6'h3F;
    d_wdata = 16'hBEEF;
    exp_push(1'b1, 16'h0000);
    step();
    check("wr_mem_en", 32'(mem_en), 32'h1);
    check("wr_mem_we", 32'(mem_we), 32'h1);
    check("wr_mem_addr", 32'(mem_addr), 32'h3F);
    check("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    d_wdata = 16'h0000;
    d_addr  = 6'h00;
    step();
    check("wr_we_one_cycle", 32'(mem_we), 32'h0);
    check("wr_d_ack", 32'(d_ack), 32'h1);
    step();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 6'h3F;
    exp_push(1'b1, 16'hBEEF);
    drain(10);
    step();
    step();
    check("d_rdata_hold", 32'(d_rdata), 32'hBEEF);

    // Simultaneous held requests from reset: F, D, F, D
    reset = 1'b0;
    #1;
    check("rst2_d_rdata", 32'(d_rdata), 32'h0);
    @(negedge clk_main);
    reset   = 1'b1;
    keep_if = 1'b1;
    keep_d  = 1'b1;
    if_req  = 1'b1;
    if_addr = 6'h05;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 6'h3F;
    exp_push(1'b0, 16'h1234);
    exp_push(1'b1, 16'hBEEF);
    exp_push(1'b0, 16'h1234);
    exp_push(1'b1, 16'hBEEF);
    drain(20);
    keep_if = 1'b0;
    keep_d  = 1'b0;
    if_req  = 1'b0;
    d_req   = 1'b0;
    repeat (3) step();

    // Continuous data requests, fetch arrives mid-access: D, F, D
    keep_d = 1'b1;
    d_req  = 1'b1;
    exp_push(1'b1, 16'hBEEF);
    step();
    if_req  = 1'b1;
    if_addr = 6'h05;
    exp_push(1'b0, 16'h1234);
    exp_push(1'b1, 16'hBEEF);
    drain(20);
    keep_d = 1'b0;
    d_req  = 1'b0;
    repeat (3) step();

    // Fetch raised and withdrawn while data is in flight: no access for it
    d_req = 1'b1;
    exp_push(1'b1, 16'hBEEF);
    step();
    if_req  = 1'b1;
    if_addr = 6'h07;
    step();
    if_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("withdrawn_no_access", 32'(mem_en), 32'h0);
    end

    // Reset during the access cycle of a write
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 6'h10;
    d_wdata = 16'h5555;
    step();
    check("pre_rst_we", 32'(mem_we), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_mem_we", 32'(mem_we), 32'h0);
    check("abort_mem_en", 32'(mem_en), 32'h0);
    check("abort_d_ack", 32'(d_ack), 32'h0);
    d_req = 1'b0;
    step();
    step();
    // Request waiting at release is granted at the first edge
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 6'h10;
    exp_push(1'b1, 16'h0A0A);
    @(negedge clk_main);
    reset = 1'b1;
    step();
    check("rel_first_grant", 32'(mem_en), 32'h1);
    check("rel_mem_addr", 32'(mem_addr), 32'h10);
    drain(10);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
